// File: rtl/instruction_cache.sv
// Direct-mapped, read-only instruction cache between the CPU fetch port and a slow
// block-oriented instruction memory. Hits return in the same cycle; misses stall via BUSYWAIT.
module instruction_cache #(
  parameter int ADDR_W  = 10,
  parameter int INDEX_W = 3,
  parameter int BLOCK_W = 128
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                FETCH_EN,
  input  logic [31:0]         PC,
  output logic [31:0]         INSTRUCTION,
  output logic                BUSYWAIT,
  output logic                MEM_READ,
  output logic [ADDR_W-5:0]   MEM_ADDRESS,
  input  logic [BLOCK_W-1:0]  MEM_READDATA,
  input  logic                MEM_BUSYWAIT
);

  localparam int TAG_W = ADDR_W - INDEX_W - 4;
  localparam int LINES = 2 ** INDEX_W;

  typedef enum logic {
    ST_IDLE,
    ST_MEM_READ
  } state_t;

  state_t                   state;
  logic                     mem_read_q;
  logic [ADDR_W-5:0]        miss_addr;
  logic [LINES-1:0]         valid;
  logic [TAG_W-1:0]         tag_store  [LINES];
  logic [BLOCK_W-1:0]       data_store [LINES];

  logic [INDEX_W-1:0]       index;
  logic [TAG_W-1:0]         tag;
  logic [1:0]               word_sel;
  logic [INDEX_W-1:0]       miss_index;
  logic [TAG_W-1:0]         miss_tag;
  logic                     hit;
  logic                     fill_done;
  logic                     unused_pc;

  assign index      = PC[3+INDEX_W:4];
  assign tag        = PC[ADDR_W-1:4+INDEX_W];
  assign word_sel   = PC[3:2];
  assign unused_pc  = ^{PC[31:ADDR_W], PC[1:0]};

  assign miss_index = miss_addr[INDEX_W-1:0];
  assign miss_tag   = miss_addr[ADDR_W-5:INDEX_W];

  assign hit        = valid[index] && (tag_store[index] == tag);
  assign fill_done  = (state == ST_MEM_READ) && !MEM_BUSYWAIT;

  // The word is presented whenever the line is valid; the stall tells the CPU whether it is usable.
  always_comb begin
    INSTRUCTION = 32'h0;
    if (valid[index]) begin
      INSTRUCTION = data_store[index][{word_sel, 5'b00000} +: 32];
    end
  end

  assign BUSYWAIT    = (state == ST_MEM_READ) || (FETCH_EN && !hit);
  assign MEM_READ    = mem_read_q;
  assign MEM_ADDRESS = miss_addr;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state      <= ST_IDLE;
      mem_read_q <= 1'b0;
      miss_addr  <= '0;
      valid      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (FETCH_EN && !hit) begin
            miss_addr  <= {tag, index};
            mem_read_q <= 1'b1;
            state      <= ST_MEM_READ;
          end
        end
        ST_MEM_READ: begin
          if (!MEM_BUSYWAIT) begin
            valid[miss_index] <= 1'b1;
            mem_read_q        <= 1'b0;
            state             <= ST_IDLE;
          end
        end
        default: begin
          mem_read_q <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

  // Arrays are only written on a completed handshake; a reset in the same cycle discards the fill.
  always_ff @(posedge CLK) begin
    if (RESET && fill_done) begin
      data_store[miss_index] <= MEM_READDATA;
      tag_store[miss_index]  <= miss_tag;
    end
  end

endmodule
